// File: rtl/bp_fe_fetch_queue.sv
// Circular fetch queue between PC generation and the backend.
// Accepting an exception message holds off further enqueues until a backend flush.
module bp_fe_fetch_queue #(
  parameter int msg_width_p = 64,
  parameter int els_p       = 8,
  parameter int exc_bit_p   = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [msg_width_p-1:0]    msg_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [msg_width_p-1:0]    msg_o,
  output logic                      v_o,
  input  logic                      ready_i,
  output logic [$clog2(els_p):0]    count_o,
  output logic                      hold_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam logic [lg_els_lp:0] full_count_lp = (lg_els_lp+1)'(els_p);

  typedef enum logic [0:0] {e_run = 1'b0, e_hold = 1'b1} state_e;

  state_e                 state_r, state_n_s;
  logic [lg_els_lp-1:0]   wr_ptr_r, rd_ptr_r;
  logic [lg_els_lp:0]     count_r;
  logic [msg_width_p-1:0] mem_r [els_p];
  logic                   hold_s, enq_s, deq_s;

  assign enq_s   = v_i & ready_o;
  assign deq_s   = v_o & ready_i;
  assign v_o     = (count_r != '0);
  assign msg_o   = mem_r[rd_ptr_r];
  assign count_o = count_r;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_run;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic: flush is the only way out of HOLD.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      e_run: begin
        if (!flush_i && enq_s && msg_i[exc_bit_p]) begin
          state_n_s = e_hold;
        end else begin
          state_n_s = e_run;
        end
      end
      e_hold: begin
        if (flush_i) begin
          state_n_s = e_run;
        end else begin
          state_n_s = e_hold;
        end
      end
      default: state_n_s = e_run;
    endcase
  end

  // Output decode; ready_o deliberately ignores v_i and any same-cycle deq.
  always_comb begin
    hold_s  = 1'b0;
    ready_o = 1'b0;
    case (state_r)
      e_run: begin
        hold_s  = 1'b0;
        ready_o = (count_r != full_count_lp) & ~flush_i;
      end
      e_hold: begin
        hold_s  = 1'b1;
        ready_o = 1'b0;
      end
      default: begin
        hold_s  = 1'b0;
        ready_o = 1'b0;
      end
    endcase
  end

  assign hold_o = hold_s;

  // Pointers and occupancy; flush drops any same-cycle enq/deq.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + lg_els_lp'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + lg_els_lp'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + (lg_els_lp+1)'(1);
        2'b01:   count_r <= count_r - (lg_els_lp+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Message storage, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wr_ptr_r] <= msg_i;
    end
  end

  bp_fe_fetch_queue_checker #(.cnt_width_p(lg_els_lp+1)) checker_i (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .deq_i   (deq_s),
    .count_i (count_r)
  );

endmodule

// Protocol checks for the fetch queue.
module bp_fe_fetch_queue_checker #(
  parameter int cnt_width_p = 4
) (
  input logic                   clk_i,
  input logic                   reset_i,
  input logic                   deq_i,
  input logic [cnt_width_p-1:0] count_i
);

  // A dequeue from an empty queue would underflow the occupancy count.
  no_deq_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    !(deq_i && (count_i == '0)));

endmodule
